// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the framed IMEM program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         LEN_W         = 16;

  // A frame length is usable when it is non-zero and fits the IMEM.
  function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                  input logic [LEN_W:0]   max_len);
    return (len != 16'd0) && ({1'b0, len} <= max_len);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes into little-endian 32-bit words and keeps the running
// XOR checksum; word/word_valid are registered and appear one cycle later.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  in_byte,
  output logic [1:0]  lane,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  csum
);

  logic [1:0]  lane_r;
  logic [23:0] low_r;
  logic [31:0] word_r;
  logic        valid_r;
  logic [7:0]  csum_r;

  // Lane shift, word hand-off and checksum accumulation.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_r  <= 2'd0;
      low_r   <= 24'd0;
      word_r  <= 32'd0;
      valid_r <= 1'b0;
      csum_r  <= 8'd0;
    end else begin
      valid_r <= 1'b0;
      if (byte_en) begin
        csum_r <= csum_r ^ in_byte;
        lane_r <= lane_r + 2'd1;
        case (lane_r)
          2'd0: low_r[7:0]   <= in_byte;
          2'd1: low_r[15:8]  <= in_byte;
          2'd2: low_r[23:16] <= in_byte;
          2'd3: begin
            word_r  <= {in_byte, low_r};
            valid_r <= 1'b1;
          end
          default: lane_r <= 2'd0;
        endcase
      end
    end
  end

  assign lane       = lane_r;
  assign word       = word_r;
  assign word_valid = valid_r;
  assign csum       = csum_r;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes a checksummed image into IMEM and holds
// the core in reset until a complete, verified frame has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  output logic              rst_im,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0]  MAX_LEN = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_s;
  logic                accept_s;
  logic                byte_en_s;
  logic                last_word_s;
  logic [LEN_W-1:0]    len_full_s;
  logic [7:0]          len_lo_r;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W:0]     word_cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                rst_im_r;
  logic                core_rst_r;
  logic                done_r;
  logic                error_r;
  logic [1:0]          lane_s;
  logic [31:0]         word_s;
  logic                word_valid_s;
  logic [7:0]          csum_s;

  assign rx_ready    = !rst && (state_r != ST_CLEAR);
  assign accept_s    = rx_valid && rx_ready;
  assign byte_en_s   = accept_s && (state_r == ST_DATA);
  assign len_full_s  = {rx_data, len_lo_r};
  assign last_word_s = ((word_cnt_r + CNT_ONE) == len_r);

  loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_r == ST_CLEAR),
    .byte_en    (byte_en_s),
    .in_byte    (rx_data),
    .lane       (lane_s),
    .word       (word_s),
    .word_valid (word_valid_s),
    .csum       (csum_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (accept_s && (rx_data == MAGIC)) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = state_r;
        end
      end
      ST_CLEAR: state_s = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept_s) begin
          state_s = ST_LEN_HI;
        end else begin
          state_s = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (!accept_s) begin
          state_s = ST_LEN_HI;
        end else if (len_ok(len_full_s, MAX_LEN)) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_ERROR;
        end
      end
      ST_DATA: begin
        // Leave on the final byte so the checksum byte can follow directly.
        if (byte_en_s && (lane_s == 2'd3) && last_word_s) begin
          state_s = ST_CSUM;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (!accept_s) begin
          state_s = ST_CSUM;
        end else if (rx_data == csum_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ERROR;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Status outputs, length capture, word count and write address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_im_r   <= 1'b0;
      core_rst_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      len_lo_r   <= 8'd0;
      len_r      <= '0;
      word_cnt_r <= '0;
      addr_r     <= '0;
    end else begin
      rst_im_r <= (state_s == ST_CLEAR);
      if (state_s == ST_CLEAR) begin
        core_rst_r <= 1'b1;
        done_r     <= 1'b0;
        error_r    <= 1'b0;
      end else if ((state_r == ST_CSUM) && (state_s == ST_DONE)) begin
        done_r     <= 1'b1;
        core_rst_r <= 1'b0;
      end else if ((state_r != ST_ERROR) && (state_s == ST_ERROR)) begin
        error_r    <= 1'b1;
        core_rst_r <= 1'b1;
      end
      if (state_r == ST_CLEAR) begin
        len_lo_r   <= 8'd0;
        len_r      <= '0;
        word_cnt_r <= '0;
        addr_r     <= '0;
      end else begin
        if (accept_s && (state_r == ST_LEN_LO)) begin
          len_lo_r <= rx_data;
        end
        if (accept_s && (state_r == ST_LEN_HI)) begin
          len_r <= len_full_s[ADDR_W:0];
        end
        if (byte_en_s && (lane_s == 2'd3)) begin
          word_cnt_r <= word_cnt_r + CNT_ONE;
        end
        if (word_valid_s) begin
          addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign write_en   = word_valid_s;
  assign write_data = word_s;
  assign write_addr = addr_r;
  assign rst_im     = rst_im_r;
  assign core_rst   = core_rst_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule
